frog_log_rider: RTL and testbench

//  Consumer of the log-motion stage. For the river lane the frog currently occupies,

---
 rtl/frog_log_rider.sv | 147 ++++++++++++++
 tb/tb_frog_log_rider.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_log_rider.sv
// Frog-on-log detector for the current river lane: overlap test, drift
// command generation and drowning detection.
module frog_log_rider #(
  parameter int FROG_W       = 32,
  parameter int X_LEFT       = 96,
  parameter int X_RIGHT      = 544,
  parameter int GRACE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] frog_x,
  input  logic       frog_in_river,
  input  logic       frog_hop,
  input  logic [9:0] log0_x,
  input  logic [9:0] log1_x,
  input  logic [9:0] log2_x,
  input  logic       log2_en,
  input  logic [9:0] log_len,
  input  logic [9:0] log_speed,
  input  logic       death_ack,
  output logic       on_log,
  output logic       drift_valid,
  output logic       drift_left,
  output logic       drown,
  output logic       riding
);

  typedef enum logic [1:0] {
    OFF_RIVER,
    LANDING,
    RIDING,
    DROWNED
  } state_t;

  localparam int CNT_W = $clog2(GRACE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [10:0] HALF_W  = 11'(FROG_W / 2);
  localparam logic [10:0] FULL_W  = 11'(FROG_W);
  localparam logic [10:0] LEFT_X  = 11'(X_LEFT);
  localparam logic [10:0] RIGHT_X = 11'(X_RIGHT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_log_q, on_log_d;
  logic             drift_valid_q, drift_valid_d;
  logic             drift_left_q, drift_left_d;
  logic             drown_q, drown_d;

  logic [10:0] c;
  logic [10:0] len_ext;
  logic        hit0, hit1, hit2;
  logic        speed_nz, dir_left;
  logic        at_left, at_right, edge_hit;

  // 11-bit arithmetic keeps log ends past x=1023 from wrapping
  always_comb begin
    c        = {1'b0, frog_x} + HALF_W;
    len_ext  = {1'b0, log_len};
    hit0     = (c >= {1'b0, log0_x}) &&
               (c < ({1'b0, log0_x} + len_ext));
    hit1     = (c >= {1'b0, log1_x}) &&
               (c < ({1'b0, log1_x} + len_ext));
    hit2     = log2_en &&
               (c >= {1'b0, log2_x}) &&
               (c < ({1'b0, log2_x} + len_ext));
    on_log_d = hit0 | hit1 | hit2;
  end

  always_comb begin
    speed_nz = |log_speed;
    dir_left = log_speed[9];
    at_right = ({1'b0, frog_x} + FULL_W) >= RIGHT_X;
    at_left  = {1'b0, frog_x} <= LEFT_X;
    edge_hit = speed_nz && (dir_left ? at_left : at_right);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drift_valid_d = 1'b0;
    drift_left_d  = 1'b0;
    unique case (state_q)
      OFF_RIVER: begin
        if (frog_in_river && frog_hop) begin
          state_d = LANDING;
          cnt_d   = '0;
        end
      end
      LANDING: begin
        cnt_d = cnt_q + 1'b1;
        if (!frog_in_river) begin
          state_d = OFF_RIVER;
        end else if (frog_hop) begin
          state_d = LANDING;
          cnt_d   = '0;
        end else if (on_log_q) begin
          state_d = RIDING;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DROWNED;
        end
      end
      RIDING: begin
        if (!frog_in_river) begin
          state_d = OFF_RIVER;
        end else if (frog_hop) begin
          state_d = LANDING;
          cnt_d   = '0;
        end else if (!on_log_q || edge_hit) begin
          state_d = DROWNED;
        end else if (speed_nz) begin
          drift_valid_d = 1'b1;
          drift_left_d  = dir_left;
        end
      end
      DROWNED: begin
        if (death_ack) state_d = OFF_RIVER;
      end
      default: state_d = OFF_RIVER;
    endcase
    drown_d = (state_d == DROWNED) && (state_q != DROWNED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= OFF_RIVER;
      cnt_q         <= '0;
      on_log_q      <= 1'b0;
      drift_valid_q <= 1'b0;
      drift_left_q  <= 1'b0;
      drown_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      on_log_q      <= on_log_d;
      drift_valid_q <= drift_valid_d;
      drift_left_q  <= drift_left_d;
      drown_q       <= drown_d;
    end
  end

  assign on_log      = on_log_q;
  assign drift_valid = drift_valid_q;
  assign drift_left  = drift_left_q;
  assign drown       = drown_q;
  assign riding      = (state_q == RIDING);

endmodule

// File: tb/tb_frog_log_rider.sv
// Bench for frog_log_rider: overlap vector table through a scoreboard
// queue, then hand-written FSM sequences.
module tb_frog_log_rider;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] frog_x;
  logic       frog_in_river;
  logic       frog_hop;
  logic [9:0] log0_x, log1_x, log2_x;
  logic       log2_en;
  logic [9:0] log_len;
  logic [9:0] log_speed;
  logic       death_ack;
  logic       on_log, drift_valid, drift_left, drown, riding;

  int checks   = 0;
  int failures = 0;

  frog_log_rider dut (
    .clk          (clk),
    .reset        (reset),
    .frog_x       (frog_x),
    .frog_in_river(frog_in_river),
    .frog_hop     (frog_hop),
    .log0_x       (log0_x),
    .log1_x       (log1_x),
    .log2_x       (log2_x),
    .log2_en      (log2_en),
    .log_len      (log_len),
    .log_speed    (log_speed),
    .death_ack    (death_ack),
    .on_log       (on_log),
    .drift_valid  (drift_valid),
    .drift_left   (drift_left),
    .drown        (drown),
    .riding       (riding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] fx;
    logic [9:0] l0;
    logic [9:0] l1;
    logic [9:0] l2;
    logic       en;
    logic [9:0] len;
    logic       exp;
  } vec_t;

  typedef struct {
    int   idx;
    logic exp;
  } sb_t;

  vec_t vecs[9];
  sb_t  sbq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act,
                       input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_on_log"}, on_log, 1'b0);
    check({tag, "_drift_valid"}, drift_valid, 1'b0);
    check({tag, "_drift_left"}, drift_left, 1'b0);
    check({tag, "_drown"}, drown, 1'b0);
    check({tag, "_riding"}, riding, 1'b0);
  endtask

  task automatic ride_at(input logic [9:0] fx, input logic [9:0] l0);
    frog_x   = fx;
    log0_x   = l0;
    frog_hop = 1'b1;
    step();
    frog_hop = 1'b0;
    step();
  endtask

  initial begin
    sb_t e;
    logic bad;
    vecs[0] = '{10'd200, 10'd180, 10'd700, 10'd0, 1'b0, 10'd96, 1'b1};
    vecs[1] = '{10'd164, 10'd180, 10'd700, 10'd0, 1'b0, 10'd96, 1'b1};
    vecs[2] = '{10'd163, 10'd180, 10'd700, 10'd0, 1'b0, 10'd96, 1'b0};
    vecs[3] = '{10'd260, 10'd180, 10'd700, 10'd0, 1'b0, 10'd96, 1'b0};
    vecs[4] = '{10'd20,  10'd180, 10'd700, 10'd0, 1'b0, 10'd96, 1'b0};
    vecs[5] = '{10'd20,  10'd180, 10'd700, 10'd0, 1'b1, 10'd96, 1'b1};
    vecs[6] = '{10'd684, 10'd180, 10'd700, 10'd0, 1'b0, 10'd96, 1'b1};
    vecs[7] = '{10'd1000, 10'd1000, 10'd0, 10'd0, 1'b0, 10'd100, 1'b1};
    vecs[8] = '{10'd1010, 10'd1000, 10'd300, 10'd0, 1'b0, 10'd20, 1'b0};

    reset = 1'b1;
    frog_x = '0; frog_in_river = 1'b0; frog_hop = 1'b0;
    log0_x = '0; log1_x = '0; log2_x = '0; log2_en = 1'b0;
    log_len = '0; log_speed = '0; death_ack = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      frog_x  = vecs[i].fx;
      log0_x  = vecs[i].l0;
      log1_x  = vecs[i].l1;
      log2_x  = vecs[i].l2;
      log2_en = vecs[i].en;
      log_len = vecs[i].len;
      sbq.push_back('{i, vecs[i].exp});
      step();
      e = sbq.pop_front();
      check($sformatf("overlap_vec%0d", e.idx), on_log, e.exp);
      check($sformatf("overlap_vec%0d_riding", e.idx), riding, 1'b0);
    end

    frog_in_river = 1'b1;
    log0_x = 10'd180; log1_x = 10'd700; log2_x = 10'd0;
    log2_en = 1'b0; log_len = 10'd96;
    frog_x = 10'd200;
    frog_hop = 1'b1;
    step();
    frog_hop = 1'b0;
    check("land_on_log", on_log, 1'b1);
    check("land_not_yet_riding", riding, 1'b0);
    step();
    check("land_riding", riding, 1'b1);

    log_speed = 10'h3FF;
    step();
    log_speed = '0;
    check("drift_l_valid", drift_valid, 1'b1);
    check("drift_l_dir", drift_left, 1'b1);
    check("drift_l_riding", riding, 1'b1);
    step();
    check("drift_l_one_cycle", drift_valid, 1'b0);

    frog_hop = 1'b1;
    log_speed = 10'd1;
    step();
    frog_hop = 1'b0;
    log_speed = '0;
    check("hop_wins_no_drift", drift_valid, 1'b0);
    check("hop_wins_landing", riding, 1'b0);
    step();
    check("hop_wins_reride", riding, 1'b1);

    frog_x = 10'd512;
    log0_x = 10'd500;
    step();
    check("edge_r_still_riding", riding, 1'b1);
    log_speed = 10'd1;
    step();
    log_speed = '0;
    check("edge_r_drown", drown, 1'b1);
    check("edge_r_no_drift", drift_valid, 1'b0);
    check("edge_r_not_riding", riding, 1'b0);
    step();
    check("edge_r_drown_pulse", drown, 1'b0);
    death_ack = 1'b1;
    step();
    death_ack = 1'b0;

    frog_x = 10'd200;
    log0_x = 10'd700;
    log1_x = 10'd800;
    frog_hop = 1'b1;
    step();
    frog_hop = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (drown !== 1'b0 || riding !== 1'b0) bad = 1'b1;
    end
    check("grace_no_early_drown", bad, 1'b0);
    step();
    check("grace_drown", drown, 1'b1);
    step();
    check("grace_drown_pulse", drown, 1'b0);
    log0_x = 10'd180;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (drown !== 1'b0 || riding !== 1'b0) bad = 1'b1;
    end
    check("drowned_holds", bad, 1'b0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    log0_x = 10'd700;
    check_all_zero("reset_drowned");
    ride_at(10'd200, 10'd180);
    check("after_reset_riding", riding, 1'b1);

    frog_x = 10'd96;
    log0_x = 10'd80;
    step();
    log_speed = 10'h3FF;
    step();
    log_speed = '0;
    check("edge_l_drown", drown, 1'b1);
    check("edge_l_no_drift", drift_valid, 1'b0);
    death_ack = 1'b1;
    step();
    death_ack = 1'b0;
    check("ack_entry_pulse_end", drown, 1'b0);
    ride_at(10'd200, 10'd180);
    check("ack_entry_exit_riding", riding, 1'b1);

    log_speed = 10'd1;
    step();
    log_speed = '0;
    check("drift_r_valid", drift_valid, 1'b1);
    check("drift_r_dir", drift_left, 1'b0);

    frog_in_river = 1'b0;
    step();
    check("leave_river_riding", riding, 1'b0);
    check("leave_river_no_drown", drown, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
